// File: rtl/seq_nibble_adder.sv
// Iterative WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice is reused
// nibble by nibble, with the carry registered between nibbles.

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are flattened so no carry ripples through the slice.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign sum   = p ^ c[3:0];
    assign c_out = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; result and flags hold the last operation
// RUN   | one nibble per cycle through the slice, idx selects the nibble
// DONE  | done pulse; result and flags valid, start ignored
module seq_nibble_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;        // already inverted for subtract
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] result_nxt;
    logic             accept;
    logic             last_nibble;

    assign slice_a     = a_q[4*idx +: 4];
    assign slice_b     = b_q[4*idx +: 4];
    assign accept      = (state == IDLE) && start;
    assign last_nibble = (state == RUN) && (idx == LAST_IDX);

    cla_4bit u_cla (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    always_comb begin
        result_nxt = result;
        result_nxt[4*idx +: 4] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            carry_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                idx     <= '0;
                carry_q <= sub;
                result  <= '0;
            end else if (state == RUN) begin
                result  <= result_nxt;
                carry_q <= slice_cout;
                idx     <= idx + 1'b1;
                if (last_nibble) begin
                    carry_out <= slice_cout;
                    overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                               && (result_nxt[WIDTH-1] != a_q[WIDTH-1]);
                    zero      <= ~|result_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_nibble_adder.sv
// Directed and randomized checks of seq_nibble_adder at WIDTH=32 against
// hand-computed values and a wide-integer reference model.

module tb_seq_nibble_adder;
    localparam int WIDTH = 32;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int passed = 0;
    int total  = 0;

    seq_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] r,
                                input logic c, input logic v, input logic z);
        check({tag, "_result"}, 64'(result), 64'(r));
        check({tag, "_carry"}, 64'(carry_out), 64'(c));
        check({tag, "_ovf"}, 64'(overflow), 64'(v));
        check({tag, "_zero"}, 64'(zero), 64'(z));
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int done_at[$];
        int cnt;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        longint           sa, sb, sr;
        logic [WIDTH:0]   ua;
        logic [WIDTH-1:0] er;
        logic             ec, ev;

        repeat (3) @(negedge clk);
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        check("add_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("add_latency", 64'(cyc), 64'(N));
        check_result("add_carry", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        finish_op("add_carry");

        start_op(32'd5, 32'd7, 1'b1);
        wait_done(cyc);
        check_result("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        finish_op("sub_borrow");

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(cyc);
        check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        finish_op("add_ovf");

        start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done(cyc);
        check_result("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        finish_op("sub_ovf");

        // Mid-run start with new operands must be ignored.
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge clk);
        a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check_result("isolate", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        a = 32'h10; b = 32'h20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        check("isolate_done_single", 64'(done), 64'd0);
        check("done_cycle_start_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        check("next_cycle_start_accepted", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(cyc);
        check_result("after_done_start", 32'h30, 1'b0, 1'b0, 1'b0);
        finish_op("after_done_start");

        // Asynchronous reset after the third RUN edge.
        start_op(32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_reset_partial", 64'(result), 64'h333);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_busy_done", 64'({busy, done}), 64'd0);
        check("mid_rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("mid_rst_no_done", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(32'd3, 32'd4, 1'b0);
        wait_done(cyc);
        check_result("post_reset", 32'd7, 1'b0, 1'b0, 1'b0);
        finish_op("post_reset");

        // Continuous start: done spacing is one full operation plus the DONE/IDLE turnaround.
        a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) done_at.push_back(i);
        end
        start = 1'b0;
        check("cont_done_count", 64'(done_at.size()), 64'd4);
        for (int i = 1; i < done_at.size(); i++)
            check("cont_done_spacing", 64'(done_at[i] - done_at[i-1]), 64'(N + 2));
        repeat (N + 3) @(negedge clk);

        // Randomized regression against a wide-integer reference.
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 16 == 0) ra = 32'h8000_0000;
            if (i % 16 == 1) rb = ra;
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            sr = rs ? sa - sb : sa + sb;
            ev = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            ua = {1'b0, ra} + {1'b0, rb};
            ec = rs ? (ra >= rb) : ua[WIDTH];
            er = rs ? ra - rb : ra + rb;
            start_op(ra, rb, rs);
            wait_done(cyc);
            check_result("rand", er, ec, ev, (er == '0));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
